// File: rtl/pe_conf_tx.sv
// rtl/pe_conf_tx.sv - PE config word serializer with start/run/abort instruction control
module pe_conf_tx #(
    parameter int PCONFDWD = 6,
    parameter int CONFWD   = 73,
    parameter int NBEAT    = (CONFWD + PCONFDWD - 1) / PCONFDWD
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                conf_valid,
    input  logic [CONFWD-1:0]   conf,
    output logic                conf_ready,
    input  logic                abort,
    input  logic                stall_in,
    output logic                pconf_dval,
    output logic [PCONFDWD-1:0] pconf_data,
    output logic                pconf_last,
    input  logic                pconf_rdy,
    output logic [3:0]          inst,
    input  logic [1:0]          status,
    output logic                busy
);

    localparam int SHW = NBEAT * PCONFDWD;
    localparam int CW  = (NBEAT > 1) ? $clog2(NBEAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_START, S_RUN} state_t;

    state_t          state_q, state_d;
    logic [SHW-1:0]  shreg_q, shreg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            dval_q, dval_d;
    logic            last_q, last_d;
    logic [3:0]      inst_q, inst_d;
    logic            busy_q, busy_d;

    logic            start_d, stall_d, ireset_d, idval_d;
    logic            conf_end_unused;

    // confEnd is deliberately ignored; the beat counter alone decides the word end
    assign conf_end_unused = status[0];

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        dval_d   = dval_q;
        last_d   = last_q;
        start_d  = 1'b0;
        stall_d  = 1'b0;
        ireset_d = 1'b0;
        idval_d  = inst_q[0];

        case (state_q)
            S_IDLE: begin
                if (abort) begin
                    ireset_d = 1'b1;
                end else if (conf_valid) begin
                    shreg_d = {{(SHW-CONFWD){1'b0}}, conf};
                    cnt_d   = '0;
                    state_d = S_SEND;
                    dval_d  = 1'b1;
                    last_d  = (NBEAT == 1);
                end
            end
            S_SEND: begin
                if (pconf_rdy) begin
                    shreg_d = shreg_q >> PCONFDWD;
                    cnt_d   = cnt_q + CW'(1);
                    last_d  = (cnt_q == CW'(NBEAT - 2));
                    if (cnt_q == CW'(NBEAT - 1)) begin
                        state_d = S_START;
                        dval_d  = 1'b0;
                        last_d  = 1'b0;
                        cnt_d   = '0;
                        start_d = 1'b1;
                    end
                end
            end
            S_START: begin
                state_d = S_RUN;
                idval_d = 1'b1;
            end
            S_RUN: begin
                if (status[1]) begin
                    state_d = S_IDLE;
                    idval_d = 1'b0;
                end else begin
                    stall_d = stall_in;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // abort overrides every in-flight event, including last-beat acceptance
        if (abort && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            shreg_d  = '0;
            cnt_d    = '0;
            dval_d   = 1'b0;
            last_d   = 1'b0;
            start_d  = 1'b0;
            stall_d  = 1'b0;
            idval_d  = 1'b0;
            ireset_d = 1'b1;
        end

        inst_d = {start_d, stall_d, ireset_d, idval_d};
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            dval_q  <= 1'b0;
            last_q  <= 1'b0;
            inst_q  <= 4'b0010;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            dval_q  <= dval_d;
            last_q  <= last_d;
            inst_q  <= inst_d;
            busy_q  <= busy_d;
        end
    end

    assign conf_ready = (state_q == S_IDLE);
    assign pconf_dval = dval_q;
    assign pconf_data = shreg_q[PCONFDWD-1:0];
    assign pconf_last = last_q;
    assign inst       = inst_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_pe_conf_tx.sv
// tb/tb_pe_conf_tx.sv - scoreboard bench for pe_conf_tx
module tb_pe_conf_tx;

    localparam int PCONFDWD = 6;
    localparam int CONFWD   = 73;
    localparam int NBEAT    = 13;

    localparam logic [CONFWD-1:0] W_NOM  = 73'h1_2345_6789_ABCD_EF01;
    localparam logic [CONFWD-1:0] W_TOP  = 73'h100_0000_0000_0000_0000;
    localparam logic [CONFWD-1:0] W_ONES = 73'h1FF_FFFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst, conf_valid, abort, stall_in, pconf_rdy;
    logic [CONFWD-1:0]   conf;
    logic [1:0]          status;
    logic                conf_ready, pconf_dval, pconf_last, busy;
    logic [PCONFDWD-1:0] pconf_data;
    logic [3:0]          inst;

    pe_conf_tx dut (
        .clk(clk), .rst(rst), .conf_valid(conf_valid), .conf(conf),
        .conf_ready(conf_ready), .abort(abort), .stall_in(stall_in),
        .pconf_dval(pconf_dval), .pconf_data(pconf_data), .pconf_last(pconf_last),
        .pconf_rdy(pconf_rdy), .inst(inst), .status(status), .busy(busy)
    );

    // hand-computed 6-bit beats, LSB chunk first
    logic [5:0] tbl_nom  [NBEAT] = '{6'h01, 6'h3C, 6'h1E, 6'h33, 6'h2B, 6'h26, 6'h38,
                                     6'h19, 6'h05, 6'h0D, 6'h12, 6'h00, 6'h00};
    logic [5:0] tbl_top  [NBEAT] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                     6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h01};
    logic [5:0] tbl_ones [NBEAT] = '{6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F,
                                     6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h01};
    logic [5:0] cur [NBEAT];

    logic [6:0] exp_q [$];
    logic [6:0] mon_exp;
    int n_vec = 0;
    int n_bad = 0;
    int n_start = 0;
    int s0, ncyc;
    logic [4:0] st_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && !abort && pconf_dval && pconf_rdy) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL beat_unexpected: got data 0x%0h, expected no beat", pconf_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("beat_data", pconf_data, mon_exp[5:0]);
                check("beat_last", pconf_last, mon_exp[6]);
            end
        end
        if (inst[3]) n_start++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic use_tbl(input int id);
        for (int i = 0; i < NBEAT; i++)
            cur[i] = (id == 0) ? tbl_nom[i] : (id == 1) ? tbl_top[i] : tbl_ones[i];
    endtask

    task automatic send_word(input logic [CONFWD-1:0] w, input int id, input int npush);
        use_tbl(id);
        for (int i = 0; i < npush; i++) exp_q.push_back({(i == NBEAT - 1), cur[i]});
        for (int i = 0; i < 20 && !conf_ready; i++) tick();
        check("conf_ready_before_send", conf_ready, 1);
        conf       = w;
        conf_valid = 1'b1;
        tick();
        conf_valid = 1'b0;
    endtask

    task automatic xfer(input int stall_beat, input int stall_len, input int abort_beat,
                        input int rst_beat, output int cycles);
        int bi, hold, cyc;
        bit stop;
        bi = 0; hold = 0; cyc = 0; stop = 1'b0;
        while (bi < NBEAT && !stop && cyc < 100) begin
            pconf_rdy = !(bi == stall_beat && hold < stall_len);
            abort     = (bi == abort_beat);
            rst       = (bi == rst_beat);
            @(negedge clk);
            if (!pconf_rdy) begin
                check("hold_data", pconf_data, cur[bi]);
                check("hold_dval", pconf_dval, 1);
            end
            tick();
            cyc++;
            if (abort || rst) begin
                stop  = 1'b1;
                abort = 1'b0;
                rst   = 1'b0;
            end else if (pconf_rdy) bi++;
            else hold++;
        end
        pconf_rdy = 1'b1;
        if (cyc >= 100) check("xfer_timeout", cyc, 0);
        cycles = cyc;
    endtask

    task automatic finish_run();
        tick();
        status = 2'b10;
        tick();
        status = 2'b00;
        @(negedge clk);
        check("done_conf_ready", conf_ready, 1);
        check("done_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; conf_valid = 1'b0; conf = '0; abort = 1'b0;
        stall_in = 1'b0; pconf_rdy = 1'b1; status = 2'b00;
        tick(); tick();
        @(negedge clk);
        check("rst_conf_ready", conf_ready, 1);
        check("rst_dval", pconf_dval, 0);
        check("rst_last", pconf_last, 0);
        check("rst_data", pconf_data, 0);
        check("rst_inst", inst, 4'b0010);
        check("rst_busy", busy, 0);
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        check("post_rst_inst", inst, 4'b0000);

        // nominal transfer, then start pulse, stall and finish
        s0 = n_start;
        send_word(W_NOM, 0, 13);
        xfer(-1, 0, -1, -1, ncyc);
        check("nom_cycles", ncyc, 13);
        @(negedge clk);
        check("nom_start", inst[3], 1);
        check("nom_dval_drop", pconf_dval, 0);
        check("nom_last_drop", pconf_last, 0);
        tick();
        stall_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            st_seen[k] = inst[2];
            check("run_inst_dval", inst[0], 1);
            check("run_no_start", inst[3], 0);
            tick();
            if (k == 1) stall_in = 1'b0;
        end
        check("run_stall_pattern", st_seen, 5'b00110);
        status = 2'b10;
        @(negedge clk);
        check("run_busy", busy, 1);
        check("run_conf_ready", conf_ready, 0);
        tick();
        status = 2'b00;
        @(negedge clk);
        check("finish_conf_ready", conf_ready, 1);
        check("finish_busy", busy, 0);
        check("finish_inst", inst, 4'b0000);
        check("nom_start_count", n_start - s0, 1);

        // backpressure at beat 4 with confEnd asserted early
        s0 = n_start;
        status = 2'b01;
        send_word(W_NOM, 0, 13);
        xfer(4, 3, -1, -1, ncyc);
        status = 2'b00;
        check("bp_cycles", ncyc, 16);
        finish_run();
        check("bp_start_count", n_start - s0, 1);

        // abort at beat 7, then a clean word
        s0 = n_start;
        send_word(W_ONES, 2, 7);
        xfer(-1, 0, 7, -1, ncyc);
        @(negedge clk);
        check("abort_dval", pconf_dval, 0);
        check("abort_inst", inst, 4'b0010);
        check("abort_busy", busy, 0);
        tick();
        @(negedge clk);
        check("abort_pulse_end", inst, 4'b0000);
        check("abort_no_start", n_start - s0, 0);
        send_word(W_ONES, 2, 13);
        xfer(-1, 0, -1, -1, ncyc);
        check("after_abort_cycles", ncyc, 13);
        finish_run();
        check("after_abort_start", n_start - s0, 1);

        // reset mid-transfer at beat 5
        send_word(W_NOM, 0, 5);
        xfer(-1, 0, -1, 5, ncyc);
        @(negedge clk);
        check("midrst_dval", pconf_dval, 0);
        check("midrst_last", pconf_last, 0);
        check("midrst_data", pconf_data, 0);
        check("midrst_inst", inst, 4'b0010);
        check("midrst_busy", busy, 0);
        check("midrst_ready", conf_ready, 1);
        send_word(W_TOP, 1, 13);
        xfer(-1, 0, -1, -1, ncyc);
        check("after_rst_cycles", ncyc, 13);
        finish_run();

        // abort coincident with last-beat acceptance
        s0 = n_start;
        send_word(W_TOP, 1, 12);
        xfer(-1, 0, 12, -1, ncyc);
        @(negedge clk);
        check("ablast_inst", inst, 4'b0010);
        check("ablast_busy", busy, 0);
        check("ablast_dval", pconf_dval, 0);
        tick();
        @(negedge clk);
        check("ablast_inst_after", inst, 4'b0000);
        check("ablast_no_start", n_start - s0, 0);

        // abort and conf_valid together in IDLE
        abort = 1'b1; conf_valid = 1'b1; conf = W_NOM;
        tick();
        abort = 1'b0; conf_valid = 1'b0;
        @(negedge clk);
        check("idle_abort_inst", inst, 4'b0010);
        check("idle_abort_busy", busy, 0);
        check("idle_abort_dval", pconf_dval, 0);
        tick();
        @(negedge clk);
        check("idle_abort_stays", busy, 0);
        check("idle_abort_no_beat", pconf_dval, 0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
